// File: rtl/bcd_pkg.sv
// Shared types and constants for the arbitrated binary-to-BCD converter.
// Imported by the dabble step and the arbiter top.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BIN_W      = 8;
  localparam int BCD_W      = 12;
  localparam int NUM_ITER   = 8;
  localparam int ADD3_LIMIT = 4;

endpackage

// File: rtl/bcd_dabble_step.sv
// One shift-and-add-3 iteration: shift a bit in, then correct each digit.
// The final iteration skips the correction.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             in_bit,
  input  logic             last,
  output logic [BCD_W-1:0] nxt
);

  logic [BCD_W-1:0] sh;

  always_comb begin
    sh  = {bcd[BCD_W-2:0], in_bit};
    nxt = sh;
    if (!last) begin
      for (int n = 0; n < BCD_W / 4; n++) begin
        if (sh[4*n +: 4] > 4'(ADD3_LIMIT))
          nxt[4*n +: 4] = sh[4*n +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one iterative binary-to-BCD engine.
// One byte is converted per grant; results are tagged with the requester.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [BIN_W*NUM_REQ-1:0] bin_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         done_id,
  output logic [BCD_W-1:0]         bcd_out
);

  localparam int CNT_W = $clog2(NUM_ITER);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   idx_q;
  logic               found;
  logic [BIN_W-1:0]   byte_q;
  logic [BCD_W-1:0]   sr;
  logic [BCD_W-1:0]   sr_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  // Lowest requester above ptr wins; otherwise lowest at or below ptr.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && i <= int'(ptr)) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && i > int'(ptr)) begin
        sel   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign last = (cnt == CNT_W'(NUM_ITER - 1));

  bcd_dabble_step u_step (
    .bcd    (sr),
    .in_bit (byte_q[BIN_W-1]),
    .last   (last),
    .nxt    (sr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd_out <= '0;
      ptr     <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      byte_q  <= '0;
      sr      <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          grant <= '0;
          if (found) begin
            grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            ptr    <= sel;
            idx_q  <= sel;
            byte_q <= bin_in[{sel, 3'b000} +: BIN_W];
            sr     <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          grant  <= '0;
          sr     <= sr_nxt;
          byte_q <= byte_q << 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            bcd_out <= sr_nxt;
            done_id <= idx_q;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Bench for bcd_convert_arbiter: timeline/arithmetic model plus directed
// literal checks, randomized traffic and an exhaustive byte sweep.
module tb_bcd_convert_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req = '0;
  logic [8*NUM_REQ-1:0]   bin_in = '0;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       done_id;
  logic [11:0]            bcd_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_convert_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bin_in  (bin_in),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic logic [11:0] dec(input int b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Model: phase -1 idle, 0 grant cycle, 8 done cycle.
  int             m_phase = -1;
  int             m_ptr = NUM_REQ - 1;
  int             m_id = 0;
  int             c;
  logic [11:0]    m_val = '0;
  logic           m_found;
  logic [NUM_REQ-1:0] e_grant = '0;
  logic           e_busy = 1'b0;
  logic           e_done = 1'b0;
  int             e_id = 0;
  logic [11:0]    e_bcd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = -1;
      m_ptr   = NUM_REQ - 1;
      e_grant = '0;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_id    = 0;
      e_bcd   = '0;
    end else begin
      cyc++;
      e_grant = '0;
      e_done  = 1'b0;
      if (m_phase < 0) begin
        m_found = 1'b0;
        for (int j = 1; j <= NUM_REQ; j++) begin
          c = (m_ptr + j) % NUM_REQ;
          if (!m_found && req[c]) begin
            m_found = 1'b1;
            m_id    = c;
            m_val   = dec(int'(bin_in[c*8 +: 8]));
            m_ptr   = c;
            e_grant = NUM_REQ'(1) << c;
            e_busy  = 1'b1;
            m_phase = 0;
          end
        end
      end else if (m_phase < 8) begin
        m_phase++;
        if (m_phase == 8) begin
          e_done = 1'b1;
          e_bcd  = m_val;
          e_id   = m_id;
        end
      end else begin
        m_phase = -1;
        e_busy  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("grant", grant, e_grant);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("done_id", done_id, e_id);
      chk("bcd_out", bcd_out, e_bcd);
      if (done)
        chk("digit_range",
            (bcd_out[11:10] == 2'd0 && bcd_out[9:8] <= 4'd2 &&
             bcd_out[7:4] <= 4'd9 && bcd_out[3:0] <= 4'd9), 1);
    end
  end

  task automatic wait_grant(output int who, output int at, input int limit);
    who = -1;
    at  = 0;
    for (int k = 0; k < limit && who < 0; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        at = cyc;
        for (int i = 0; i < NUM_REQ; i++)
          if (grant[i]) who = i;
      end
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=none required=grant");
    end
  endtask

  task automatic run_one(input int idx, input int b, input logic [11:0] exp);
    int who, at;
    req = '0;
    bin_in[idx*8 +: 8] = 8'(b);
    req[idx] = 1'b1;
    wait_grant(who, at, 30);
    chk("grant_id", who, idx);
    req = '0;
    repeat (8) @(negedge clk);
    chk("lit_done", done, 1);
    chk("lit_bcd", bcd_out, exp);
    chk("lit_id", done_id, idx);
    chk("lit_busy_done", busy, 1);
    @(negedge clk);
    chk("lit_busy_after", busy, 0);
  endtask

  task automatic idle_wait();
    req = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int who, at, last_at;
    int bytes4 [4];
    logic [11:0] exp4 [4];
    int fair_seq [5];

    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", done_id, 0);
    chk("rst_bcd", bcd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_one(0, 8'hFF, 12'h255);
    idle_wait();
    run_one(3, 0, 12'h000);
    idle_wait();
    run_one(3, 9, 12'h009);
    idle_wait();

    bytes4 = '{1, 99, 200, 128};
    exp4   = '{12'h001, 12'h099, 12'h200, 12'h128};
    for (int k = 0; k < 4; k++) bin_in[k*8 +: 8] = 8'(bytes4[k]);
    req = 4'hF;
    last_at = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who, at, 30);
      chk("rr_order", who, k);
      if (k > 0) chk("rr_gap", at - last_at, 10);
      last_at = at;
      if (who >= 0) req[who] = 1'b0;
      repeat (8) @(negedge clk);
      chk("rr_bcd", bcd_out, exp4[k]);
      chk("rr_id", done_id, k);
    end
    idle_wait();

    fair_seq = '{0, 2, 0, 1, 2};
    req = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      bin_in = {$urandom, $urandom} >> 32;
      wait_grant(who, at, 30);
      chk("fair_order", who, fair_seq[k]);
      if (k == 2) req[1] = 1'b1;
      if (who == 1) req[1] = 1'b0;
    end
    idle_wait();

    bin_in[23:16] = 8'd37;
    req = 4'b0100;
    wait_grant(who, at, 30);
    req = '0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_id", done_id, 0);
    chk("mid_rst_bcd", bcd_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_one(2, 37, 12'h037);
    idle_wait();

    for (int k = 0; k < 600; k++) begin
      req = NUM_REQ'($urandom_range(0, 15));
      bin_in = $urandom;
      @(negedge clk);
    end
    idle_wait();

    req = 4'b0010;
    for (int v = 0; v < 256; v++) begin
      bin_in[15:8] = 8'(v);
      wait_grant(who, at, 30);
    end
    idle_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
